radio_ddr_chan_framer: RTL and testbench
========================================

Name: radio_ddr_chan_framer

Overview:
Parametrised RX deinterleaver and TX interleaver for a frame-delimited, time-multiplexed radio sample stream. Supports 1, 2 or 4 channels, with the active count selectable at run time.
- Sits between the DDR capture/launch primitives (already demuxed to one I/Q pair per clock) and the per-channel radio cores.
- Adds frame-alignment recovery, TX handshake and underrun reporting.

Parameters:
SAMP_W, 12, bits per I or Q sample
NUM_CHAN, 2, maximum channels; legal values 1, 2, 4

Ports:
radio_clk  in  1  sample clock; sole clock
radio_rst_n  in  1  asynchronous, active-low reset
chan_code  in  2  active channels N: 0=1, 1=2, 2=4; 3 or N>NUM_CHAN clamps to NUM_CHAN; quasi-static
rx_i, rx_q  in  SAMP_W  captured sample, one per clock
rx_frame  in  1  high on channel-0 slot
rx_i_out, rx_q_out  out  NUM_CHAN*SAMP_W  channel c at [c*SAMP_W +: SAMP_W]
rx_stb  out  1  one-cycle pulse: rx_*_out updated
rx_align_err  out  1  one-cycle pulse on frame mismatch
tx_i_in, tx_q_in  in  NUM_CHAN*SAMP_W  vector, one sample per channel
tx_valid  in  1  vector offered
tx_ready  out  1  vector accepted when valid & ready
tx_i, tx_q  out  SAMP_W  interleaved output sample
tx_frame  out  1  high on channel-0 slot
tx_underrun  out  1  one-cycle pulse: slot-0 boundary with no data while running

Behaviour:
- Reset: every output is 0, including tx_ready. rx FSM=SEARCH, tx FSM=IDLE, slot counters=0, hold register empty.
- N is derived from registered chan_code. A change of N flushes both paths the next cycle: rx to SEARCH, tx to IDLE with hold emptied, no error pulses.
- RX FSM, SEARCH: ignore data until rx_frame=1. Write slot 0, set rx_slot=1, go to LOCKED.
- RX FSM, LOCKED: each cycle write slot rx_slot into a staging register; rx_slot increments modulo N. Expected rx_frame is (rx_slot==0).
  - Mismatch: pulse rx_align_err and discard the partial vector. If rx_frame=1, treat the sample as slot 0 and stay LOCKED; else go to SEARCH.
  - After slot N-1 is written, the staging register copies atomically into rx_*_out and rx_stb pulses on the next cycle. Latency is 1 cycle after the last sample.
- RX outputs hold between strobes. Channels >= N drive 0.
- N=1: rx_frame is ignored, there is no alignment error, and rx_stb pulses every cycle with latency 1.
- TX: one-entry hold register plus a shift register. tx_slot counts modulo N whenever not in reset; tx_frame=(tx_slot==0) is registered with the data. N=1 gives tx_frame constantly 1.
- tx_ready = started & (~hold_full | (tx_slot==N-1)). started sets 1 on the first clock after reset release. Accept when valid & ready.
- At tx_slot==N-1: if hold is full, move it into the shift register and go to RUN; simultaneous accept refills hold in the same cycle.
- If hold is empty at that boundary: shift register loads zeros. In RUN, also pulse tx_underrun and go to IDLE.
- IDLE transmits zeros with tx_frame still cycling and no underrun.
- tx_i/tx_q are registered; output latency from shift-register slot to pins is 1 cycle.
- Reset mid-operation drops all data immediately (asynchronous assertion). Release is synchronous to the design; the integrator provides a synchronized release.

Optional Feature:
RADIO_FRAMER_ERR_CNT_EN
- Defined: adds input err_cnt_clr (1) and outputs rx_align_err_cnt and tx_underrun_cnt (16 each).
  - Counters are saturating at 16'hFFFF and reset to 0.
  - err_cnt_clr zeroes both counters; clear wins over a simultaneous increment.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

Decomposition:
- Package radio_framer_pkg:
  - rx FSM enum {SEARCH, LOCKED} and tx FSM enum {IDLE, RUN}
  - chan_code localparams
  - function n_from_code(code, NUM_CHAN) returning the clamped N
  - ERR_CNT_W=16
- One natural sub-module: radio_framer_tx (hold register, shift register, slot counter, underrun).
- The RX path stays in the top.

Test Plan:
- N=2, SAMP_W=12: drive rx (I,Q) = (0x101,0x201) frame=1, then (0x102,0x202) frame=0. Next cycle rx_stb=1, ch0=(0x101,0x201), ch1=(0x102,0x202).
- N=4 locked, rx_frame=1 at slot 2 -> rx_align_err pulse, no rx_stb, re-lock; next complete vector strobes correctly.
- N=2 TX: continuous valid vectors ch0=0x0AA, ch1=0x055 -> tx_i alternates 0x0AA/0x055 with tx_frame 1/0, never underruns; tx_ready pattern 0,1,0,1.
- TX RUN, then tx_valid dropped -> one tx_underrun pulse at the next slot-0 boundary, zeros output, IDLE; no further pulses.
- chan_code 1->2 mid-stream -> flush, no error pulses; first rx_stb only after a fresh frame=1 plus 4 samples.
- With RADIO_FRAMER_ERR_CNT_EN: 3 forced misalignments -> rx_align_err_cnt=3; err_cnt_clr concurrent with a 4th misalignment -> count 0.

Source files
------------

// File: rtl/radio_framer_pkg.sv
// Shared types, channel-code constants and helpers for the radio DDR channel framer.
package radio_framer_pkg;

   typedef enum logic {SEARCH, LOCKED} rx_state_t;
   typedef enum logic {IDLE, RUN} tx_state_t;

   localparam logic [1:0] CODE_1CH = 2'd0;
   localparam logic [1:0] CODE_2CH = 2'd1;
   localparam logic [1:0] CODE_4CH = 2'd2;
   localparam logic [1:0] CODE_MAX = 2'd3;

   localparam int MAX_CHAN  = 4;
   localparam int ERR_CNT_W = 16;

   // Active channel count for a code, clamped to what the instance was built for.
   function automatic logic [2:0] n_from_code(input logic [1:0] code, input int num_chan);
      logic [2:0] n;
      case (code)
         CODE_1CH: n = 3'd1;
         CODE_2CH: n = 3'd2;
         CODE_4CH: n = 3'd4;
         default:  n = 3'(num_chan);
      endcase
      if (int'(n) > num_chan) n = 3'(num_chan);
      return n;
   endfunction

endpackage

// File: rtl/radio_framer_tx.sv
// TX interleaver: one-vector hold register feeding a per-frame shift register, slot
// counter with frame marker, handshake and underrun detection.
module radio_framer_tx
   import radio_framer_pkg::*;
#(
   parameter int SAMP_W   = 12,
   parameter int NUM_CHAN = 2
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic [2:0]                 n,
   input  logic                       flush,
   input  logic [NUM_CHAN*SAMP_W-1:0] tx_i_in,
   input  logic [NUM_CHAN*SAMP_W-1:0] tx_q_in,
   input  logic                       tx_valid,
   output logic                       tx_ready,
   output logic [SAMP_W-1:0]          tx_i,
   output logic [SAMP_W-1:0]          tx_q,
   output logic                       tx_frame,
   output logic                       tx_underrun
);

   tx_state_t         state;
   logic              started;
   logic              hold_full;
   logic [1:0]        slot;
   logic [1:0]        n_last;
   logic              boundary;
   logic              accept;
   logic [SAMP_W-1:0] hold_i  [MAX_CHAN];
   logic [SAMP_W-1:0] hold_q  [MAX_CHAN];
   logic [SAMP_W-1:0] shift_i [MAX_CHAN];
   logic [SAMP_W-1:0] shift_q [MAX_CHAN];

   assign n_last   = 2'(n - 3'd1);
   assign boundary = (slot == n_last);
   // Never claim acceptance in the flush cycle, since that vector would be dropped.
   assign tx_ready = started & ~flush & (~hold_full | boundary);
   assign accept   = tx_valid & tx_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         started     <= 1'b0;
         hold_full   <= 1'b0;
         slot        <= '0;
         tx_i        <= '0;
         tx_q        <= '0;
         tx_frame    <= 1'b0;
         tx_underrun <= 1'b0;
         for (int c = 0; c < MAX_CHAN; c++) begin
            hold_i[c]  <= '0;
            hold_q[c]  <= '0;
            shift_i[c] <= '0;
            shift_q[c] <= '0;
         end
      end else begin
         started     <= 1'b1;
         tx_underrun <= 1'b0;
         tx_i        <= shift_i[slot];
         tx_q        <= shift_q[slot];
         tx_frame    <= (slot == 2'd0);
         if (flush) begin
            state     <= IDLE;
            hold_full <= 1'b0;
            slot      <= '0;
            for (int c = 0; c < MAX_CHAN; c++) begin
               shift_i[c] <= '0;
               shift_q[c] <= '0;
            end
         end else begin
            slot <= boundary ? 2'd0 : slot + 2'd1;
            if (boundary) begin
               for (int c = 0; c < MAX_CHAN; c++) begin
                  shift_i[c] <= hold_full ? hold_i[c] : '0;
                  shift_q[c] <= hold_full ? hold_q[c] : '0;
               end
               if (hold_full) begin
                  state <= RUN;
               end else if (state == RUN) begin
                  tx_underrun <= 1'b1;
                  state       <= IDLE;
               end
            end
            if (accept) begin
               hold_full <= 1'b1;
               for (int c = 0; c < NUM_CHAN; c++) begin
                  hold_i[c] <= tx_i_in[c*SAMP_W +: SAMP_W];
                  hold_q[c] <= tx_q_in[c*SAMP_W +: SAMP_W];
               end
            end else if (boundary) begin
               hold_full <= 1'b0;
            end
         end
      end
   end

endmodule

// File: rtl/radio_ddr_chan_framer.sv
// Time-multiplexed radio framer: RX deinterleaver with frame-alignment recovery plus TX
// interleaver. Defining RADIO_FRAMER_ERR_CNT_EN adds saturating error counters.
module radio_ddr_chan_framer
   import radio_framer_pkg::*;
#(
   parameter int SAMP_W   = 12,
   parameter int NUM_CHAN = 2
) (
   input  logic                       radio_clk,
   input  logic                       radio_rst_n,
   input  logic [1:0]                 chan_code,
   input  logic [SAMP_W-1:0]          rx_i,
   input  logic [SAMP_W-1:0]          rx_q,
   input  logic                       rx_frame,
   output logic [NUM_CHAN*SAMP_W-1:0] rx_i_out,
   output logic [NUM_CHAN*SAMP_W-1:0] rx_q_out,
   output logic                       rx_stb,
   output logic                       rx_align_err,
   input  logic [NUM_CHAN*SAMP_W-1:0] tx_i_in,
   input  logic [NUM_CHAN*SAMP_W-1:0] tx_q_in,
   input  logic                       tx_valid,
   output logic                       tx_ready,
   output logic [SAMP_W-1:0]          tx_i,
   output logic [SAMP_W-1:0]          tx_q,
   output logic                       tx_frame,
   output logic                       tx_underrun
`ifdef RADIO_FRAMER_ERR_CNT_EN
   ,
   input  logic                       err_cnt_clr,
   output logic [ERR_CNT_W-1:0]       rx_align_err_cnt,
   output logic [ERR_CNT_W-1:0]       tx_underrun_cnt
`endif
);

   logic [1:0]        code_q;
   logic [2:0]        n_cur;
   logic [2:0]        n_q;
   logic [1:0]        n_last;
   logic              flush;
   rx_state_t         rx_state;
   logic [1:0]        rx_slot;
   logic [SAMP_W-1:0] stage_i [MAX_CHAN];
   logic [SAMP_W-1:0] stage_q [MAX_CHAN];
   logic [SAMP_W-1:0] out_i   [MAX_CHAN];
   logic [SAMP_W-1:0] out_q   [MAX_CHAN];

   assign n_cur  = n_from_code(code_q, NUM_CHAN);
   assign n_last = 2'(n_cur - 3'd1);
   // A new channel count is seen one cycle before n_q catches up; that cycle flushes.
   assign flush  = (n_cur != n_q);

   always_ff @(posedge radio_clk or negedge radio_rst_n) begin
      if (!radio_rst_n) begin
         code_q <= CODE_1CH;
         n_q    <= 3'd1;
      end else begin
         code_q <= chan_code;
         n_q    <= n_cur;
      end
   end

   always_ff @(posedge radio_clk or negedge radio_rst_n) begin
      if (!radio_rst_n) begin
         rx_state     <= SEARCH;
         rx_slot      <= '0;
         rx_stb       <= 1'b0;
         rx_align_err <= 1'b0;
         for (int c = 0; c < MAX_CHAN; c++) begin
            stage_i[c] <= '0;
            stage_q[c] <= '0;
            out_i[c]   <= '0;
            out_q[c]   <= '0;
         end
      end else begin
         rx_stb       <= 1'b0;
         rx_align_err <= 1'b0;
         if (flush) begin
            rx_state <= SEARCH;
            rx_slot  <= '0;
         end else if (n_cur == 3'd1) begin
            rx_state <= SEARCH;
            rx_slot  <= '0;
            out_i[0] <= rx_i;
            out_q[0] <= rx_q;
            rx_stb   <= 1'b1;
         end else if (rx_state == SEARCH) begin
            if (rx_frame) begin
               stage_i[0] <= rx_i;
               stage_q[0] <= rx_q;
               rx_slot    <= 2'd1;
               rx_state   <= LOCKED;
            end
         end else if (rx_frame != (rx_slot == 2'd0)) begin
            // Misaligned: the partial vector is abandoned; a frame marker restarts it.
            rx_align_err <= 1'b1;
            if (rx_frame) begin
               stage_i[0] <= rx_i;
               stage_q[0] <= rx_q;
               rx_slot    <= 2'd1;
            end else begin
               rx_state <= SEARCH;
               rx_slot  <= '0;
            end
         end else begin
            stage_i[rx_slot] <= rx_i;
            stage_q[rx_slot] <= rx_q;
            if (rx_slot == n_last) begin
               for (int c = 0; c < MAX_CHAN; c++) begin
                  out_i[c] <= (rx_slot == 2'(c)) ? rx_i : stage_i[c];
                  out_q[c] <= (rx_slot == 2'(c)) ? rx_q : stage_q[c];
               end
               rx_stb  <= 1'b1;
               rx_slot <= '0;
            end else begin
               rx_slot <= rx_slot + 2'd1;
            end
         end
      end
   end

   for (genvar c = 0; c < NUM_CHAN; c++) begin : g_rx_out
      assign rx_i_out[c*SAMP_W +: SAMP_W] = (3'(c) < n_cur) ? out_i[c] : '0;
      assign rx_q_out[c*SAMP_W +: SAMP_W] = (3'(c) < n_cur) ? out_q[c] : '0;
   end

   radio_framer_tx #(
      .SAMP_W   (SAMP_W),
      .NUM_CHAN (NUM_CHAN)
   ) u_tx (
      .clk         (radio_clk),
      .rst_n       (radio_rst_n),
      .n           (n_cur),
      .flush       (flush),
      .tx_i_in     (tx_i_in),
      .tx_q_in     (tx_q_in),
      .tx_valid    (tx_valid),
      .tx_ready    (tx_ready),
      .tx_i        (tx_i),
      .tx_q        (tx_q),
      .tx_frame    (tx_frame),
      .tx_underrun (tx_underrun)
   );

`ifdef RADIO_FRAMER_ERR_CNT_EN
   function automatic logic [ERR_CNT_W-1:0] sat_inc(input logic [ERR_CNT_W-1:0] v);
      return (&v) ? v : v + 1'b1;
   endfunction

   always_ff @(posedge radio_clk or negedge radio_rst_n) begin
      if (!radio_rst_n) begin
         rx_align_err_cnt <= '0;
         tx_underrun_cnt  <= '0;
      end else if (err_cnt_clr) begin
         rx_align_err_cnt <= '0;
         tx_underrun_cnt  <= '0;
      end else begin
         if (rx_align_err) rx_align_err_cnt <= sat_inc(rx_align_err_cnt);
         if (tx_underrun)  tx_underrun_cnt  <= sat_inc(tx_underrun_cnt);
      end
   end
`endif

endmodule

// File: tb/tb_radio_ddr_chan_framer.sv
// Self-checking bench for radio_ddr_chan_framer (4-channel build); exercises the
// RADIO_FRAMER_ERR_CNT_EN counters when that macro is defined.
module tb_radio_ddr_chan_framer;

   localparam int W  = 12;
   localparam int NC = 4;
   localparam int VW = W * NC;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic [1:0]    chan_code = 2'd0;
   logic [W-1:0]  rx_i = '0, rx_q = '0;
   logic          rx_frame = 1'b0;
   logic [VW-1:0] rx_i_out, rx_q_out;
   logic          rx_stb, rx_align_err;
   logic [VW-1:0] tx_i_in = '0, tx_q_in = '0;
   logic          tx_valid = 1'b0;
   logic          tx_ready;
   logic [W-1:0]  tx_i, tx_q;
   logic          tx_frame, tx_underrun;
`ifdef RADIO_FRAMER_ERR_CNT_EN
   logic          err_cnt_clr = 1'b0;
   logic [15:0]   rx_align_err_cnt, tx_underrun_cnt;
`endif

   int n_chk = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   radio_ddr_chan_framer #(.SAMP_W(W), .NUM_CHAN(NC)) dut (
      .radio_clk    (clk),
      .radio_rst_n  (rst_n),
      .chan_code    (chan_code),
      .rx_i         (rx_i),
      .rx_q         (rx_q),
      .rx_frame     (rx_frame),
      .rx_i_out     (rx_i_out),
      .rx_q_out     (rx_q_out),
      .rx_stb       (rx_stb),
      .rx_align_err (rx_align_err),
      .tx_i_in      (tx_i_in),
      .tx_q_in      (tx_q_in),
      .tx_valid     (tx_valid),
      .tx_ready     (tx_ready),
      .tx_i         (tx_i),
      .tx_q         (tx_q),
      .tx_frame     (tx_frame),
      .tx_underrun  (tx_underrun)
`ifdef RADIO_FRAMER_ERR_CNT_EN
      ,
      .err_cnt_clr      (err_cnt_clr),
      .rx_align_err_cnt (rx_align_err_cnt),
      .tx_underrun_cnt  (tx_underrun_cnt)
`endif
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      n_chk++;
      assert (obs === expv) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic int n_of(input logic [1:0] code);
      return (code == 2'd0) ? 1 : (code == 2'd1) ? 2 : 4;
   endfunction

   function automatic logic [VW-1:0] masked(input logic [VW-1:0] v, input int n);
      logic [VW-1:0] r;
      r = '0;
      for (int c = 0; c < n; c++) r[c*W +: W] = v[c*W +: W];
      return r;
   endfunction

   // Reset, then two cycles so the registered channel code has settled.
   task automatic do_reset(input logic [1:0] code);
      rst_n = 1'b0; chan_code = code; rx_frame = 1'b0; rx_i = '0; rx_q = '0; tx_valid = 1'b0;
      step(); step();
      rst_n = 1'b1;
      step(); step();
   endtask

   task automatic rx_drive(input logic [W-1:0] i, input logic [W-1:0] q, input logic f,
                           input logic stb, input logic err, input string tag);
      rx_i = i; rx_q = q; rx_frame = f;
      step();
      chk({tag, "_stb"}, rx_stb, stb);
      chk({tag, "_err"}, rx_align_err, err);
   endtask

   // Random well-formed frames separated by random gaps; expectations come from
   // the frame structure that was generated.
   task automatic rx_block(input logic [1:0] code, input int nfr);
      int n, g;
      logic [VW-1:0] vi, vq, ni, nq;
      logic [W-1:0] si, sq;
      bit have, locked;
      n = n_of(code); have = 0; locked = 0; vi = '0; vq = '0; ni = '0; nq = '0;
      chan_code = code; rx_frame = 1'b0;
      step(); step();
      if (n == 1) begin
         for (int k = 0; k < nfr; k++) begin
            si = W'($urandom); sq = W'($urandom);
            rx_i = si; rx_q = sq; rx_frame = 1'($urandom);
            step();
            chk("n1_stb", rx_stb, 1'b1);
            chk("n1_err", rx_align_err, 1'b0);
            chk("n1_i", rx_i_out, VW'(si));
            chk("n1_q", rx_q_out, VW'(sq));
         end
      end else begin
         for (int f = 0; f < nfr; f++) begin
            g = $urandom_range(0, 2);
            for (int k = 0; k < g; k++) begin
               rx_i = W'($urandom); rx_q = W'($urandom); rx_frame = 1'b0;
               step();
               chk("gap_err", rx_align_err, locked && (k == 0));
               chk("gap_stb", rx_stb, 1'b0);
               if (have) chk("gap_hold_i", rx_i_out, masked(vi, n));
            end
            if (g > 0) locked = 0;
            for (int s = 0; s < n; s++) begin
               si = W'($urandom); sq = W'($urandom);
               ni[s*W +: W] = si; nq[s*W +: W] = sq;
               rx_i = si; rx_q = sq; rx_frame = (s == 0);
               step();
               if (s == n - 1) begin vi = ni; vq = nq; have = 1; locked = 1; end
               chk("fr_stb", rx_stb, s == n - 1);
               chk("fr_err", rx_align_err, 1'b0);
               if (have) begin
                  chk("fr_i", rx_i_out, masked(vi, n));
                  chk("fr_q", rx_q_out, masked(vq, n));
               end
            end
         end
      end
   endtask

   // TX reference: frames of N slots; each frame carries the oldest buffered vector
   // (buffer holds one) or zeros, pins lag the frame slot by one cycle.
   int            m_n, m_ph;
   bit            m_run;
   logic [VW-1:0] m_buf_i[$], m_buf_q[$];
   logic [VW-1:0] m_cur_i, m_cur_q;

   task automatic tx_start(input logic [1:0] code);
      do_reset(code);
      m_n = n_of(code); m_ph = 0; m_run = 0;
      m_buf_i.delete(); m_buf_q.delete();
      m_cur_i = '0; m_cur_q = '0;
   endtask

   task automatic tx_cycle(input logic valid, input logic [VW-1:0] vi, input logic [VW-1:0] vq);
      bit rdy, ur, last;
      logic [W-1:0] oi, oq;
      tx_valid = valid; tx_i_in = vi; tx_q_in = vq;
      last = (m_ph == m_n - 1);
      rdy  = (m_buf_i.size() == 0) || last;
      chk("tx_ready", tx_ready, rdy);
      oi = m_cur_i[m_ph*W +: W]; oq = m_cur_q[m_ph*W +: W]; ur = 0;
      if (last) begin
         if (m_buf_i.size() > 0) begin
            m_cur_i = m_buf_i.pop_front(); m_cur_q = m_buf_q.pop_front(); m_run = 1;
         end else begin
            m_cur_i = '0; m_cur_q = '0; ur = m_run; m_run = 0;
         end
      end
      if (valid && rdy) begin m_buf_i.push_back(vi); m_buf_q.push_back(vq); end
      step();
      chk("tx_i", tx_i, oi);
      chk("tx_q", tx_q, oq);
      chk("tx_frame", tx_frame, m_ph == 0);
      chk("tx_underrun", tx_underrun, ur);
      m_ph = (m_ph + 1) % m_n;
   endtask

   initial begin
      logic [VW-1:0] vi, vq;
      logic [3:0] pat;
      int urs;

      repeat (3) @(posedge clk);
      #1;
      chk("rst_rx_i_out", rx_i_out, '0);
      chk("rst_rx_q_out", rx_q_out, '0);
      chk("rst_rx_stb", rx_stb, 1'b0);
      chk("rst_rx_err", rx_align_err, 1'b0);
      chk("rst_tx_ready", tx_ready, 1'b0);
      chk("rst_tx_i", tx_i, '0);
      chk("rst_tx_q", tx_q, '0);
      chk("rst_tx_frame", tx_frame, 1'b0);
      chk("rst_tx_underrun", tx_underrun, 1'b0);

      // Two-channel deinterleave
      do_reset(2'd1);
      rx_drive(12'h101, 12'h201, 1'b1, 1'b0, 1'b0, "n2_s0");
      rx_drive(12'h102, 12'h202, 1'b0, 1'b1, 1'b0, "n2_s1");
      chk("n2_i_out", rx_i_out, 48'h000_000_102_101);
      chk("n2_q_out", rx_q_out, 48'h000_000_202_201);
      rx_drive(12'h103, 12'h203, 1'b1, 1'b0, 1'b0, "n2_next");
      chk("n2_hold", rx_i_out, 48'h000_000_102_101);

      // Four channels, frame marker arrives at slot 2 and re-locks
      do_reset(2'd2);
      rx_drive(12'h011, 12'h021, 1'b1, 1'b0, 1'b0, "mis_a0");
      rx_drive(12'h012, 12'h022, 1'b0, 1'b0, 1'b0, "mis_a1");
      rx_drive(12'h0B0, 12'h0C0, 1'b1, 1'b0, 1'b1, "mis_b0");
      rx_drive(12'h0B1, 12'h0C1, 1'b0, 1'b0, 1'b0, "mis_b1");
      rx_drive(12'h0B2, 12'h0C2, 1'b0, 1'b0, 1'b0, "mis_b2");
      rx_drive(12'h0B3, 12'h0C3, 1'b0, 1'b1, 1'b0, "mis_b3");
      chk("mis_i_out", rx_i_out, 48'h0B3_0B2_0B1_0B0);
      chk("mis_q_out", rx_q_out, 48'h0C3_0C2_0C1_0C0);

      // Channel count change mid-stream flushes without error pulses
      do_reset(2'd1);
      rx_drive(12'h301, 12'h401, 1'b1, 1'b0, 1'b0, "fl_a0");
      rx_drive(12'h302, 12'h402, 1'b0, 1'b1, 1'b0, "fl_a1");
      chan_code = 2'd2;
      rx_drive(12'h303, 12'h403, 1'b1, 1'b0, 1'b0, "fl_x");
      rx_drive(12'h304, 12'h404, 1'b0, 1'b0, 1'b0, "fl_flush");
      rx_drive(12'h305, 12'h405, 1'b0, 1'b0, 1'b0, "fl_srch0");
      rx_drive(12'h306, 12'h406, 1'b0, 1'b0, 1'b0, "fl_srch1");
      rx_drive(12'h310, 12'h410, 1'b1, 1'b0, 1'b0, "fl_b0");
      rx_drive(12'h311, 12'h411, 1'b0, 1'b0, 1'b0, "fl_b1");
      rx_drive(12'h312, 12'h412, 1'b0, 1'b0, 1'b0, "fl_b2");
      rx_drive(12'h313, 12'h413, 1'b0, 1'b1, 1'b0, "fl_b3");
      chk("fl_i_out", rx_i_out, 48'h313_312_311_310);

      // Randomised RX across all channel codes (code 3 clamps to four)
      rx_block(2'd0, 12);
      rx_block(2'd1, 10);
      rx_block(2'd2, 8);
      rx_block(2'd3, 8);
      rx_block(2'd1, 6);

      // Two-channel TX with continuous valid, then valid dropped
      tx_start(2'd1);
      vi = {24'h0, 12'h055, 12'h0AA};
      vq = {24'h0, 12'h0F0, 12'h00F};
      pat = '0; urs = 0;
      for (int k = 0; k < 10; k++) begin
         if (k >= 2 && k < 6) pat = {pat[2:0], tx_ready};
         tx_cycle(1'b1, vi, vq);
         if (tx_underrun) urs++;
      end
      chk("tx_ready_pattern", pat, 4'b0101);
      chk("tx_no_underrun", urs, 0);
      tx_cycle(1'b1, vi, vq);
      chk("tx_alt_ch0", {tx_frame, tx_i}, {1'b1, 12'h0AA});
      tx_cycle(1'b1, vi, vq);
      chk("tx_alt_ch1", {tx_frame, tx_i}, {1'b0, 12'h055});
      urs = 0;
      for (int k = 0; k < 10; k++) begin
         tx_cycle(1'b0, '0, '0);
         if (tx_underrun) urs++;
      end
      chk("tx_underrun_once", urs, 1);
      chk("tx_idle_zero", tx_i, '0);

      // Randomised TX per channel count
      for (int cc = 0; cc < 4; cc++) begin
         tx_start(2'(cc));
         for (int k = 0; k < 40; k++) begin
            tx_cycle(($urandom_range(0, 3) != 0) && (k < 30), VW'({$urandom, $urandom}),
                     VW'({$urandom, $urandom}));
         end
      end

      // Asynchronous reset assertion mid-stream clears outputs without a clock edge
      tx_start(2'd2);
      for (int k = 0; k < 9; k++) tx_cycle(1'b1, VW'({$urandom, $urandom}), VW'({$urandom, $urandom}));
      rst_n = 1'b0;
      #1;
      chk("arst_tx_i", tx_i, '0);
      chk("arst_tx_ready", tx_ready, 1'b0);
      chk("arst_rx_i_out", rx_i_out, '0);

`ifdef RADIO_FRAMER_ERR_CNT_EN
      do_reset(2'd1);
      rx_drive(12'h001, 12'h001, 1'b1, 1'b0, 1'b0, "cnt_lock");
      rx_drive(12'h002, 12'h002, 1'b1, 1'b0, 1'b1, "cnt_m1");
      rx_drive(12'h003, 12'h003, 1'b1, 1'b0, 1'b1, "cnt_m2");
      rx_drive(12'h004, 12'h004, 1'b1, 1'b0, 1'b1, "cnt_m3");
      rx_drive(12'h005, 12'h005, 1'b0, 1'b1, 1'b0, "cnt_f1");
      rx_drive(12'h006, 12'h006, 1'b1, 1'b0, 1'b0, "cnt_f2");
      chk("cnt_rx_3", rx_align_err_cnt, 16'd3);
      chk("cnt_tx_0", tx_underrun_cnt, 16'd0);
      rx_drive(12'h007, 12'h007, 1'b1, 1'b0, 1'b1, "cnt_m4");
      err_cnt_clr = 1'b1;
      rx_drive(12'h008, 12'h008, 1'b0, 1'b1, 1'b0, "cnt_clr");
      err_cnt_clr = 1'b0;
      chk("cnt_clr_wins", rx_align_err_cnt, 16'd0);
      rx_drive(12'h009, 12'h009, 1'b1, 1'b0, 1'b0, "cnt_after");
      chk("cnt_stays_0", rx_align_err_cnt, 16'd0);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
